// File: rtl/wb_commit_queue.sv
// In-order writeback queue: buffers completed MEM results, retires one per cycle
// to the register file and trace port, and forwards the youngest queued result to ID.

module wb_bypass_port #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int DEPTH  = 4
) (
  input  logic [RA_W-1:0]              q_addr_i,
  input  logic [DEPTH-1:0]             ent_vld_i,
  input  logic [DEPTH-1:0]             ent_we_i,
  input  logic [DEPTH-1:0][RA_W-1:0]   ent_dest_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);
  // Entries arrive oldest-first, so the last match in the scan is the youngest.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (ent_vld_i[j] && ent_we_i[j] && ent_dest_i[j] == q_addr_i && q_addr_i != '0) begin
        hit_o  = 1'b1;
        data_o = ent_data_i[j];
      end
    end
  end
endmodule

module wb_commit_queue #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RA_W   = 5,
  parameter int DEPTH  = 4,
  parameter int NQ     = 2,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ms_to_ws_valid,
  input  logic [PC_W-1:0]      ms_pc,
  input  logic                 ms_gr_we,
  input  logic [RA_W-1:0]      ms_dest,
  input  logic [DATA_W-1:0]    ms_result,
  output logic                 ws_allowin,
  input  logic                 rf_ready,
  output logic                 rf_we,
  output logic [RA_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  input  logic [NQ*RA_W-1:0]   q_addr,
  output logic [NQ-1:0]        q_hit,
  output logic [NQ*DATA_W-1:0] q_data,
  output logic                 ws_to_ds_valid,
  output logic [PW:0]          ws_count,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              gr_we;
    logic [RA_W-1:0]   dest;
    logic [DATA_W-1:0] result;
  } ent_t;

  ent_t                       ent_q [DEPTH];
  ent_t                       hd;
  logic [PW:0]                head_q, head_d, tail_q, tail_d, count;
  logic                       empty, full, pop, push;
  logic [31:0]                pc32, data32;
  logic [4:0]                 dest5;
  logic [DEPTH-1:0]           ord_vld, ord_we;
  logic [DEPTH-1:0][RA_W-1:0]   ord_dest;
  logic [DEPTH-1:0][DATA_W-1:0] ord_data;

  // Wrap bit in the pointer MSB separates full from empty.
  assign count      = tail_q - head_q;
  assign empty      = head_q == tail_q;
  assign full       = (head_q ^ tail_q) == {1'b1, {PW{1'b0}}};
  assign pop        = !empty && rf_ready;
  assign ws_allowin = !full || pop;
  assign push       = ms_to_ws_valid && ws_allowin;

  always_comb begin
    head_d = head_q + (PW+1)'(pop);
    tail_d = tail_q + (PW+1)'(push);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Payload needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push)
      ent_q[tail_q[PW-1:0]] <= '{pc: ms_pc, gr_we: ms_gr_we, dest: ms_dest, result: ms_result};
  end

  assign hd       = ent_q[head_q[PW-1:0]];
  assign rf_we    = pop && hd.gr_we && hd.dest != '0;
  assign rf_waddr = hd.dest;
  assign rf_wdata = hd.result;

  if (PC_W >= 32) begin : g_pc_trunc
    assign pc32 = hd.pc[31:0];
  end else begin : g_pc_ext
    assign pc32 = {{(32-PC_W){1'b0}}, hd.pc};
  end
  if (RA_W >= 5) begin : g_wn_trunc
    assign dest5 = hd.dest[4:0];
  end else begin : g_wn_ext
    assign dest5 = {{(5-RA_W){1'b0}}, hd.dest};
  end
  if (DATA_W >= 32) begin : g_wd_trunc
    assign data32 = hd.result[31:0];
  end else begin : g_wd_ext
    assign data32 = {{(32-DATA_W){1'b0}}, hd.result};
  end

  assign debug_wb_pc       = pop ? pc32   : '0;
  assign debug_wb_rf_wnum  = pop ? dest5  : '0;
  assign debug_wb_rf_wdata = pop ? data32 : '0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign ws_to_ds_valid    = !empty;
  assign ws_count          = count;

  // Present the queue oldest-first to the bypass ports.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      logic [PW-1:0] idx;
      idx         = head_q[PW-1:0] + PW'(j);
      ord_vld[j]  = (PW+1)'(j) < count;
      ord_we[j]   = ent_q[idx].gr_we;
      ord_dest[j] = ent_q[idx].dest;
      ord_data[j] = ent_q[idx].result;
    end
  end

  for (genvar k = 0; k < NQ; k++) begin : g_byp
    wb_bypass_port #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH)) u_byp (
      .q_addr_i  (q_addr[k*RA_W +: RA_W]),
      .ent_vld_i (ord_vld),
      .ent_we_i  (ord_we),
      .ent_dest_i(ord_dest),
      .ent_data_i(ord_data),
      .hit_o     (q_hit[k]),
      .data_o    (q_data[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed plus randomized checking of wb_commit_queue against a queue-based reference model.

module tb_wb_commit_queue;
  localparam int DATA_W = 32, PC_W = 32, RA_W = 5, DEPTH = 4, NQ = 2;
  localparam int PW = $clog2(DEPTH);

  logic                 clk = 1'b0;
  logic                 resetn = 1'b1;
  logic                 ms_to_ws_valid = 1'b0;
  logic [PC_W-1:0]      ms_pc = '0;
  logic                 ms_gr_we = 1'b0;
  logic [RA_W-1:0]      ms_dest = '0;
  logic [DATA_W-1:0]    ms_result = '0;
  logic                 ws_allowin;
  logic                 rf_ready = 1'b0;
  logic                 rf_we;
  logic [RA_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic [NQ*RA_W-1:0]   q_addr = '0;
  logic [NQ-1:0]        q_hit;
  logic [NQ*DATA_W-1:0] q_data;
  logic                 ws_to_ds_valid;
  logic [PW:0]          ws_count;
  logic [31:0]          debug_wb_pc;
  logic [3:0]           debug_wb_rf_wen;
  logic [4:0]           debug_wb_rf_wnum;
  logic [31:0]          debug_wb_rf_wdata;

  wb_commit_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .RA_W(RA_W), .DEPTH(DEPTH), .NQ(NQ)) dut (
    .clk(clk), .resetn(resetn),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_result(ms_result), .ws_allowin(ws_allowin),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data),
    .ws_to_ds_valid(ws_to_ds_valid), .ws_count(ws_count),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic              we;
    logic [RA_W-1:0]   dest;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs derived from the model queue and the current inputs.
  task automatic check_all();
    bit   pop, full, exp_we, hit;
    ent_t h;
    logic [RA_W-1:0]   qa;
    logic [DATA_W-1:0] d;
    pop  = mq.size() != 0 && rf_ready;
    full = mq.size() == DEPTH;
    h    = '{pc: '0, we: 1'b0, dest: '0, data: '0};
    if (pop) h = mq[0];
    exp_we = pop && h.we && h.dest != 0;
    chk("allowin",  ws_allowin, !full || pop);
    chk("count",    ws_count, mq.size());
    chk("nonempty", ws_to_ds_valid, mq.size() != 0);
    chk("rf_we",    rf_we, exp_we);
    chk("dbg_wen",  debug_wb_rf_wen, {4{exp_we}});
    chk("dbg_pc",   debug_wb_pc, h.pc);
    chk("dbg_wnum", debug_wb_rf_wnum, h.dest);
    chk("dbg_wdata", debug_wb_rf_wdata, h.data);
    if (exp_we) begin
      chk("rf_waddr", rf_waddr, h.dest);
      chk("rf_wdata", rf_wdata, h.data);
    end
    for (int k = 0; k < NQ; k++) begin
      qa  = q_addr[k*RA_W +: RA_W];
      hit = 1'b0;
      d   = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!hit && mq[i].we && mq[i].dest == qa && qa != 0) begin
          hit = 1'b1;
          d   = mq[i].data;
        end
      end
      chk($sformatf("q_hit%0d", k), q_hit[k], hit);
      chk($sformatf("q_data%0d", k), q_data[k*DATA_W +: DATA_W], d);
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, update model at posedge.
  task automatic cycle(input bit v, input logic [PC_W-1:0] pc, input bit we,
                       input logic [RA_W-1:0] dest, input logic [DATA_W-1:0] data,
                       input bit rdy, input logic [NQ*RA_W-1:0] qa);
    bit acc, popx;
    ms_to_ws_valid = v; ms_pc = pc; ms_gr_we = we; ms_dest = dest; ms_result = data;
    rf_ready = rdy; q_addr = qa;
    #1;
    check_all();
    popx = mq.size() != 0 && rdy;
    acc  = v && (mq.size() < DEPTH || popx);
    @(posedge clk);
    if (popx) void'(mq.pop_front());
    if (acc) mq.push_back('{pc: pc, we: we, dest: dest, data: data});
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, '0, rdy, '0);
  endtask

  initial begin
    // Reset state
    #1 resetn = 1'b0;
    #1;
    chk("rst_count",   ws_count, 0);
    chk("rst_allowin", ws_allowin, 1);
    chk("rst_rf_we",   rf_we, 0);
    chk("rst_q_hit",   q_hit, 0);
    chk("rst_valid",   ws_to_ds_valid, 0);
    chk("rst_dbg_pc",  debug_wb_pc, 0);
    @(negedge clk);
    resetn = 1'b1;
    idle(1'b1, 1);

    // Single push, commit next cycle
    cycle(1'b1, 32'h1c00_0000, 1'b1, 5'd5, 32'hA5A5, 1'b1, '0);
    ms_to_ws_valid = 1'b0; #1;
    chk("t1_we",    rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'hA5A5);
    chk("t1_wen",   debug_wb_rf_wen, 4'hF);
    chk("t1_pc",    debug_wb_pc, 32'h1c00_0000);
    @(negedge clk);
    mq.delete();
    idle(1'b1, 1);
    chk("t1_count0", ws_count, 0);

    // Backpressure: fifth push refused, then in-order drain
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h100 + 4*i, 1'b1, RA_W'(i + 1), 32'h1000 + i, 1'b0, '0);
    chk("bp_count", ws_count, 4);
    chk("bp_allow", ws_allowin, 0);
    idle(1'b1, 5);

    // Full queue with continuous push/pop across pointer wrap
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h200 + 4*i, 1'b1, RA_W'(i + 8), 32'h2000 + i, 1'b0, '0);
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 32'h300 + 4*i, 1'b1, RA_W'(i + 1), 32'h3000 + i, 1'b1, '0);
    chk("wrap_count", ws_count, 4);
    idle(1'b1, 5);

    // Youngest-match forwarding
    cycle(1'b1, 32'h400, 1'b1, 5'd3, 32'h11, 1'b0, '0);
    cycle(1'b1, 32'h404, 1'b1, 5'd3, 32'h22, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, {5'd0, 5'd3});
    chk("byp_hit0",  q_hit[0], 1);
    chk("byp_data0", q_data[DATA_W-1:0], 32'h22);
    chk("byp_hit1",  q_hit[1], 0);
    idle(1'b1, 3);

    // dest=0 commits with pc visible, no write, never forwarded
    cycle(1'b1, 32'h500, 1'b1, 5'd0, 32'hFF, 1'b0, '0);
    idle(1'b1, 2);

    // Reset mid-operation with three queued entries
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h600 + 4*i, 1'b1, 5'd7, 32'h6000 + i, 1'b0, '0);
    ms_to_ws_valid = 1'b0; rf_ready = 1'b1; q_addr = {5'd7, 5'd7};
    resetn = 1'b0;
    #1;
    chk("mrst_count", ws_count, 0);
    chk("mrst_we",    rf_we, 0);
    chk("mrst_hit",   q_hit, 0);
    mq.delete();
    @(negedge clk);
    resetn = 1'b1;
    cycle(1'b1, 32'h700, 1'b1, 5'd9, 32'h7777, 1'b1, '0);
    idle(1'b1, 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
            RA_W'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 7,
            {RA_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7))});
    idle(1'b1, 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
